// File: rtl/simcell_pkg.sv
// Purpose : shared types and helpers for the simcell register-cell family.
// Latency : n/a (package only).
// Backpressure: n/a; contents are the mode enum, the mode decode and clog2.
package simcell_pkg;

    // One operation per rising clock edge.
    typedef enum logic [1:0] {
        MODE_RESET   = 2'd0,
        MODE_SCAN    = 2'd1,
        MODE_CAPTURE = 2'd2,
        MODE_HOLD    = 2'd3
    } mode_t;

    // Ceiling log2 for elaboration-time sizing.
    // Returns the number of bits needed to hold values 0..value-1.
    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        while ((1 << bits) < value) begin
            bits = bits + 1;
        end
        return bits;
    endfunction

    // The priority between the controls lives here and nowhere else:
    // reset beats scan, scan beats capture, and capture beats hold.
    function automatic mode_t mode_of(input logic r, input logic se, input logic e);
        mode_t m;
        if (r) begin
            m = MODE_RESET;
        end else if (se) begin
            m = MODE_SCAN;
        end else if (e) begin
            m = MODE_CAPTURE;
        end else begin
            m = MODE_HOLD;
        end
        return m;
    endfunction

endpackage

// File: rtl/simcell_dff_stage.sv
// Purpose : one WIDTH-bit stage of the simcell pipeline. It supports parallel capture and a serial scan shift.
// Latency : one C edge from D (capture) or SI (scan) to Q.
// Backpressure: none. The stage updates only in the mode decoded by the parent and holds otherwise.
//
// Ports:
//   C    - clock. Every update happens on the rising edge.
//   mode - decoded operation for this edge. All stages share it.
//   D    - parallel data in. This is the previous stage's Q, or the cell's D for stage 0.
//   SI   - serial data in. This is the previous stage's SO, or the cell's SI for stage 0.
//   Q    - stage contents.
//   SO   - serial data out, equal to the MSB of Q.
module simcell_dff_stage
    import simcell_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             C,
    input  mode_t            mode,
    input  logic [WIDTH-1:0] D,
    input  logic             SI,
    output logic [WIDTH-1:0] Q,
    output logic             SO
);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] shifted;

    // During a scan, bit i moves up to bit i+1 and SI enters at bit 0.
    // A one-bit stage simply takes SI.
    generate
        if (WIDTH == 1) begin : g_shift_narrow
            assign shifted = SI;
        end else begin : g_shift_wide
            assign shifted = {q_r[WIDTH-2:0], SI};
        end
    endgenerate

    always_ff @(posedge C) begin
        case (mode)
            MODE_RESET:   q_r <= RESET_VAL;
            MODE_SCAN:    q_r <= shifted;
            MODE_CAPTURE: q_r <= D;
            default:      q_r <= q_r;
        endcase
    end

    assign Q  = q_r;
    assign SO = q_r[WIDTH-1];

endmodule

// File: rtl/simcell_dff_pipe.sv
// Purpose : STAGES-deep, WIDTH-bit DFF pipeline. It has synchronous reset to RESET_VAL, a clock enable, a full-chain scan, and fill tracking.
// Latency : Q shows D after exactly STAGES enabled edges. Edges with E low stretch this latency without losing data.
// Backpressure: none. E=0 freezes all state, and the only status is V (pipeline full of captured data).
//
// Ports:
//   C  - clock. All state updates happen on the rising edge.
//   R  - synchronous active-high reset. It has the highest priority.
//   E  - capture/advance enable.
//   SE - scan enable. Scan beats capture.
//   SI - scan data in. It enters bit 0 of stage 0.
//   D  - parallel data in.
//   Q  - contents of the last stage.
//   SO - scan data out, equal to the MSB of the last stage.
//   V  - high once STAGES captures have happened since the last reset.
module simcell_dff_pipe
    import simcell_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               STAGES    = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             C,
    input  logic             R,
    input  logic             E,
    input  logic             SE,
    input  logic             SI,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             SO,
    output logic             V
);

    // A zero-depth or zero-width cell has no meaningful netlist mapping, so refuse to build one.
    generate
        if (STAGES < 1) begin : g_bad_stages
            $error("simcell_dff_pipe: STAGES must be >= 1");
        end
        if (WIDTH < 1) begin : g_bad_width
            $error("simcell_dff_pipe: WIDTH must be >= 1");
        end
    endgenerate

    localparam int                FILL_W   = clog2(STAGES + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(STAGES);

    mode_t             mode;
    logic [WIDTH-1:0]  stage_q  [STAGES];
    logic              stage_so [STAGES];
    logic [FILL_W-1:0] fill;

    assign mode = mode_of(R, SE, E);

    // The stages form a single chain. Stage 0 is fed from the cell inputs.
    // Each later stage takes the parallel output (Q) and the serial output (SO) of the stage before it.
    // This makes scan behave as one WIDTH*STAGES-bit shift register.
    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            if (k == 0) begin : g_head
                simcell_dff_stage #(
                    .WIDTH     (WIDTH),
                    .RESET_VAL (RESET_VAL)
                ) u_stage (
                    .C    (C),
                    .mode (mode),
                    .D    (D),
                    .SI   (SI),
                    .Q    (stage_q[k]),
                    .SO   (stage_so[k])
                );
            end else begin : g_body
                simcell_dff_stage #(
                    .WIDTH     (WIDTH),
                    .RESET_VAL (RESET_VAL)
                ) u_stage (
                    .C    (C),
                    .mode (mode),
                    .D    (stage_q[k-1]),
                    .SI   (stage_so[k-1]),
                    .Q    (stage_q[k]),
                    .SO   (stage_so[k])
                );
            end
        end
    endgenerate

    // Fill counts captures since reset and saturates at STAGES.
    // Scan leaves it alone. Scan moves bits without creating new captured words,
    // so V keeps describing the data that was captured before the scan.
    always_ff @(posedge C) begin
        case (mode)
            MODE_RESET: fill <= '0;
            MODE_CAPTURE: begin
                if (fill != FILL_MAX) begin
                    fill <= fill + 1'b1;
                end
            end
            default: fill <= fill;
        endcase
    end

    // All outputs come straight from state, so there is no path from D, SI, E or SE to them.
    assign Q  = stage_q[STAGES-1];
    assign SO = stage_so[STAGES-1];
    assign V  = (fill == FILL_MAX);

    // Unknown values on the controls would make the mode ambiguous. Flag them in simulation.
    a_ctrl_known: assert property (@(posedge C) !$isunknown({R, SE, E}));

endmodule

// File: tb/tb_simcell_dff_pipe.sv
module tb_simcell_dff_pipe;

    logic       C;
    logic       R, E, SE, SI;
    logic [7:0] D;

    // Instance a: 8x3, reset value A5. Instance b: 4x2, reset value 0. Instance c: 8x1, reset value 3C.
    logic [7:0] qa, qc;
    logic [3:0] qb;
    logic       soa, sob, soc, va, vb, vc;

    simcell_dff_pipe #(.WIDTH(8), .STAGES(3), .RESET_VAL(8'hA5)) dut_a (
        .C(C), .R(R), .E(E), .SE(SE), .SI(SI), .D(D), .Q(qa), .SO(soa), .V(va));
    simcell_dff_pipe #(.WIDTH(4), .STAGES(2), .RESET_VAL(4'h0)) dut_b (
        .C(C), .R(R), .E(E), .SE(SE), .SI(SI), .D(D[3:0]), .Q(qb), .SO(sob), .V(vb));
    simcell_dff_pipe #(.WIDTH(8), .STAGES(1), .RESET_VAL(8'h3C)) dut_c (
        .C(C), .R(R), .E(E), .SE(SE), .SI(SI), .D(D), .Q(qc), .SO(soc), .V(vc));

    initial begin
        C = 1'b0;
        forever #5 C = ~C;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    // The reference model treats each cell as one flat bit string.
    // The last stage is the top WIDTH bits.
    // Capture appends a word at the bottom. Scan appends a bit at the bottom.
    // Bits that fall off the top are lost.
    logic [23:0] ma;
    logic [7:0]  mb;
    logic [7:0]  mc;
    int          fa, fb, fc;
    bit          mvalid = 0;

    always @(posedge C) begin
        if (R) begin
            ma = {3{8'hA5}};
            mb = 8'h00;
            mc = 8'h3C;
            fa = 0;
            fb = 0;
            fc = 0;
            mvalid = 1;
        end else if (SE) begin
            ma = {ma[22:0], SI};
            mb = {mb[6:0], SI};
            mc = {mc[6:0], SI};
        end else if (E) begin
            ma = {ma[15:0], D};
            mb = {mb[3:0], D[3:0]};
            mc = D;
            fa = (fa < 3) ? fa + 1 : 3;
            fb = (fb < 2) ? fb + 1 : 2;
            fc = (fc < 1) ? fc + 1 : 1;
        end
    end

    // Compare on every falling edge once the model has seen a reset.
    always @(negedge C) begin
        if (mvalid) begin
            check("a_Q",  32'(qa),  32'(ma[23:16]));
            check("a_SO", 32'(soa), 32'(ma[23]));
            check("a_V",  32'(va),  32'(fa == 3));
            check("b_Q",  32'(qb),  32'(mb[7:4]));
            check("b_SO", 32'(sob), 32'(mb[7]));
            check("b_V",  32'(vb),  32'(fb == 2));
            check("c_Q",  32'(qc),  32'(mc));
            check("c_SO", 32'(soc), 32'(mc[7]));
            check("c_V",  32'(vc),  32'(fc == 1));
        end
    end

    // Apply the inputs for one edge and return 1 time unit after that edge.
    task automatic step(input logic r, input logic se, input logic e,
                        input logic si, input logic [7:0] d);
        R = r; SE = se; E = e; SI = si; D = d;
        @(posedge C);
        #1;
    endtask

    logic [7:0] scan_pat;

    initial begin
        R = 1'b0; SE = 1'b0; E = 1'b0; SI = 1'b0; D = 8'h00;
        scan_pat = 8'b1011_0010;  // bits in shift order: 1,0,1,1,0,0,1,0

        // 1: reset, then hold
        step(1, 0, 0, 0, 8'h00);
        check("t1_a_Q_rst",  32'(qa),  32'h A5);
        check("t1_a_SO_rst", 32'(soa), 32'h1);
        check("t1_a_V_rst",  32'(va),  32'h0);
        check("t1_c_Q_rst",  32'(qc),  32'h3C);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0, 8'hEE);
        end
        check("t1_a_Q_hold", 32'(qa), 32'h A5);
        check("t1_a_V_hold", 32'(va), 32'h0);

        // 2: consecutive captures
        step(0, 0, 1, 0, 8'h01);
        check("t2_c_V_first", 32'(vc), 32'h1);
        check("t2_c_Q_first", 32'(qc), 32'h01);
        step(0, 0, 1, 0, 8'h02);
        check("t2_a_V_e2", 32'(va), 32'h0);
        check("t2_b_V_e2", 32'(vb), 32'h1);
        step(0, 0, 1, 0, 8'h03);
        check("t2_a_Q_e3", 32'(qa), 32'h01);
        check("t2_a_V_e3", 32'(va), 32'h1);
        check("t2_b_Q_e3", 32'(qb), 32'h2);
        step(0, 0, 1, 0, 8'h04);
        check("t2_a_Q_e4", 32'(qa), 32'h02);
        check("t2_a_V_e4", 32'(va), 32'h1);

        // 3: gaps in E
        step(0, 0, 1, 0, 8'h11);
        step(0, 0, 0, 0, 8'h5A);
        step(0, 0, 0, 0, 8'h6B);
        step(0, 0, 1, 0, 8'h22);
        step(0, 0, 1, 0, 8'h33);
        check("t3_a_Q", 32'(qa), 32'h11);
        check("t3_a_V", 32'(va), 32'h1);

        // 4: scan on the 4x2 cell
        step(1, 0, 0, 0, 8'h00);
        for (int i = 7; i >= 0; i--) begin
            step(0, 1, 0, scan_pat[i], 8'h00);
        end
        check("t4_b_SO_first", 32'(sob), 32'h1);
        check("t4_b_V_scan",   32'(vb),  32'h0);
        check("t4_a_Q_scan",   32'(qa),  32'h A5);
        for (int i = 7; i >= 0; i--) begin
            check("t4_b_SO_replay", 32'(sob), 32'(scan_pat[i]));
            step(0, 1, 1, 0, 8'h0F);
        end
        check("t4_b_Q_drained", 32'(qb), 32'h0);
        check("t4_b_V_after",   32'(vb), 32'h0);

        // 5: priority
        step(1, 1, 1, 1, 8'hFF);
        check("t5_a_Q_rst", 32'(qa), 32'h A5);
        check("t5_a_V_rst", 32'(va), 32'h0);
        step(0, 1, 1, 0, 8'hFF);
        check("t5_a_Q_scan", 32'(qa), 32'h4B);
        check("t5_a_V_scan", 32'(va), 32'h0);
        check("t5_c_Q_scan", 32'(qc), 32'h78);

        // 6: mid-fill reset
        step(1, 0, 0, 0, 8'h00);
        step(0, 0, 1, 0, 8'hAA);
        step(0, 0, 1, 0, 8'hBB);
        step(1, 0, 1, 0, 8'hCC);
        check("t6_a_Q_rst", 32'(qa), 32'h A5);
        check("t6_a_V_rst", 32'(va), 32'h0);
        step(0, 0, 1, 0, 8'h10);
        step(0, 0, 1, 0, 8'h20);
        check("t6_a_V_two", 32'(va), 32'h0);
        step(0, 0, 1, 0, 8'h30);
        check("t6_a_Q_refill", 32'(qa), 32'h10);
        check("t6_a_V_refill", 32'(va), 32'h1);
        check("t6_c_Q_refill", 32'(qc), 32'h30);

        step(0, 0, 0, 0, 8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
